// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the registered ALU (alu_seq):
//   - SEL_W        : opcode width
//   - OP_*         : opcode values (0..4 keep the legacy 4-bit ALU meaning)
//   - state_e      : top-level FSM state encoding
//   - flags_t      : status flag bundle held in the output register
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int SEL_W = 4;

    localparam logic [SEL_W-1:0] OP_ADD = 4'd0;
    localparam logic [SEL_W-1:0] OP_SUB = 4'd1;
    localparam logic [SEL_W-1:0] OP_AND = 4'd2;
    localparam logic [SEL_W-1:0] OP_OR  = 4'd3;
    localparam logic [SEL_W-1:0] OP_NOT = 4'd4;
    localparam logic [SEL_W-1:0] OP_XOR = 4'd5;
    localparam logic [SEL_W-1:0] OP_SHL = 4'd6;
    localparam logic [SEL_W-1:0] OP_SHR = 4'd7;
    localparam logic [SEL_W-1:0] OP_MUL = 4'd8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
        logic illegal;
    } flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// -----------------------------------------------------------------------------
// alu_seq_if
//   Handshake bundle between the operand scheduler (master) and alu_seq
//   (slave), including the result/flag return path to writeback.
//   Input side : in_valid/in_ready, a, b, sel
//   Output side: out_valid/out_ready, result, result_hi, flag_z/n/c/v, illegal
// -----------------------------------------------------------------------------
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic [WIDTH-1:0]           a;
    logic [WIDTH-1:0]           b;
    logic [alu_pkg::SEL_W-1:0]  sel;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTH-1:0]           result;
    logic [WIDTH-1:0]           result_hi;
    logic                       flag_z;
    logic                       flag_n;
    logic                       flag_c;
    logic                       flag_v;
    logic                       illegal;

    modport master (
        output in_valid, a, b, sel, out_ready,
        input  in_ready, out_valid, result, result_hi,
               flag_z, flag_n, flag_c, flag_v, illegal
    );

    modport slave (
        input  in_valid, a, b, sel, out_ready,
        output in_ready, out_valid, result, result_hi,
               flag_z, flag_n, flag_c, flag_v, illegal
    );
endinterface

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
//   Unsigned shift-add multiplier, one partial product per cycle, WIDTH steps.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     start      : load operands (only pulsed while not busy)
//     a, b       : multiplicand, multiplier
//     busy       : a multiplication is in progress
//     done       : this cycle performs the final step
//     prod       : product after this cycle's step; complete when done = 1
//   prod/done are combinational from the accumulator so the caller can
//   capture the finished product on the same edge as the final step.
// -----------------------------------------------------------------------------
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);
    localparam int CNT_W = $clog2(WIDTH);

    logic               busy_q,   busy_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [2*WIDTH-1:0] step_sum;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = CNT_W'(WIDTH - 1);
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
        end else if (busy_q) begin
            acc_d    = step_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == '0);
    assign prod = step_sum;

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
//   Registered ALU with valid/ready handshakes on both sides.
//   Single-cycle ops (ADD SUB AND OR NOT XOR SHL SHR, illegal) have latency 1;
//   MUL runs on alu_mul_seq and presents its result WIDTH cycles after accept.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : alu_seq_if.slave (operands in, result/flags out)
//   WIDTH must match the WIDTH of the connected interface instance.
// -----------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);

    state_e           state_q,     state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    flags_t           flags_q,     flags_d;

    logic               accept;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH-1:0] alu_res;
    flags_t           alu_flags;
    logic [WIDTH:0]   wide;
    logic [SH_W-1:0]  shamt;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (bus.a),
        .b     (bus.b),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    // Gating with rst_n keeps in_ready low while reset is asserted.
    // A held result blocks new input unless it drains this same cycle.
    assign bus.in_ready = rst_n && (state_q == ST_IDLE) && !mul_busy
                          && (!out_valid_q || bus.out_ready);
    assign accept = bus.in_valid && bus.in_ready;

    // Single-cycle datapath. ADD/SUB run at WIDTH+1 bits so the top bit is
    // the carry (ADD) or the borrow (SUB, set exactly when a < b).
    always_comb begin
        wide      = '0;
        alu_res   = '0;
        alu_flags = '0;
        // Low bits of b are the shift amount, i.e. modulo WIDTH for a
        // power-of-two WIDTH.
        shamt     = bus.b[SH_W-1:0];

        case (bus.sel)
            OP_ADD: begin
                wide        = {1'b0, bus.a} + {1'b0, bus.b};
                alu_res     = wide[WIDTH-1:0];
                alu_flags.c = wide[WIDTH];
                alu_flags.v = (bus.a[WIDTH-1] == bus.b[WIDTH-1])
                              && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                wide        = {1'b0, bus.a} - {1'b0, bus.b};
                alu_res     = wide[WIDTH-1:0];
                alu_flags.c = wide[WIDTH];
                alu_flags.v = (bus.a[WIDTH-1] != bus.b[WIDTH-1])
                              && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_NOT:  alu_res = ~bus.b;
            OP_XOR:  alu_res = bus.a ^ bus.b;
            OP_SHL:  alu_res = bus.a << shamt;
            OP_SHR:  alu_res = bus.a >> shamt;
            OP_MUL:  alu_res = '0;  // result comes from alu_mul_seq
            default: alu_flags.illegal = 1'b1;
        endcase

        alu_flags.z = (alu_res == '0);
        alu_flags.n = alu_res[WIDTH-1];
    end

    // Next-state and output-register logic. A drained result without a new
    // load clears out_valid but leaves the data registers untouched.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flags_d     = flags_q;
        mul_start   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.sel == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = ST_BUSY;
                    end else begin
                        result_d    = alu_res;
                        result_hi_d = '0;
                        flags_d     = alu_flags;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (mul_done) begin
                    result_d          = mul_prod[WIDTH-1:0];
                    result_hi_d       = mul_prod[2*WIDTH-1:WIDTH];
                    flags_d           = '0;
                    flags_d.z         = (mul_prod[WIDTH-1:0] == '0);
                    flags_d.n         = mul_prod[WIDTH-1];
                    flags_d.c         = |mul_prod[2*WIDTH-1:WIDTH];
                    out_valid_d       = 1'b1;
                    state_d           = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flags_q     <= flags_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.flag_z    = flags_q.z;
    assign bus.flag_n    = flags_q.n;
    assign bus.flag_c    = flags_q.c;
    assign bus.flag_v    = flags_q.v;
    assign bus.illegal   = flags_q.illegal;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
//   Scoreboard bench for alu_seq (WIDTH = 8). The driver pushes the expected
//   response of every accepted operation; an independent monitor pops and
//   compares on each output transfer. Directed scenarios cover flags, MUL
//   latency, backpressure, illegal opcodes, shift wrap and mid-MUL reset,
//   followed by randomized traffic with random output backpressure.
// -----------------------------------------------------------------------------
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         z;
        logic         n;
        logic         c;
        logic         v;
        logic         ill;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   bp_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the opcode definitions.
    function automatic exp_t model(input int unsigned a, input int unsigned b, input int unsigned sel);
        exp_t        e;
        int unsigned r;
        int          sa, sb, ss;
        int unsigned p;
        e  = '{default: '0};
        r  = 0;
        sa = (a >= 128) ? int'(a) - 256 : int'(a);
        sb = (b >= 128) ? int'(b) - 256 : int'(b);
        case (sel)
            0: begin r = a + b; e.c = (r > 255); ss = sa + sb; e.v = (ss > 127) || (ss < -128); end
            1: begin r = a - b; e.c = (a < b);   ss = sa - sb; e.v = (ss > 127) || (ss < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = ~b;
            5: r = a ^ b;
            6: r = a << (b % W);
            7: r = a >> (b % W);
            8: begin p = a * b; r = p % 256; e.hi = W'(p / 256); e.c = (p / 256) != 0; end
            default: begin r = 0; e.ill = 1'b1; end
        endcase
        e.res = r[W-1:0];
        e.z   = (e.res == 0);
        e.n   = (e.res >= 128);
        return e;
    endfunction

    // Monitor: every output transfer must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got result=%0h with no pending op", bus.result);
                end else begin
                    e = exp_q.pop_front();
                    check("result",    bus.result,    e.res);
                    check("result_hi", bus.result_hi, e.hi);
                    check("flag_z",    bus.flag_z,    e.z);
                    check("flag_n",    bus.flag_n,    e.n);
                    check("flag_c",    bus.flag_c,    e.c);
                    check("flag_v",    bus.flag_v,    e.v);
                    check("illegal",   bus.illegal,   e.ill);
                end
            end
        end
    end

    // Random output backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) bus.out_ready = ($urandom_range(0, 9) < 7);
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [SEL_W-1:0] sel);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.sel      = sel;
        @(negedge clk);
        while (!bus.in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 200 cycles");
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            return;
        end
        exp_q.push_back(model(a, b, sel));
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic mul_latency(input logic [W-1:0] a, input logic [W-1:0] b);
        int cyc      = 0;
        bit ready_lo = 1'b1;
        send(a, b, OP_MUL);
        while (cyc < 40) begin
            if (bus.in_ready) ready_lo = 1'b0;
            @(posedge clk);
            #1 cyc++;
            if (bus.out_valid) break;
        end
        check("mul_latency", cyc, W);
        check("mul_in_ready_low", ready_lo, 1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_in_ready"},  bus.in_ready,  0);
        check({name, "_out_valid"}, bus.out_valid, 0);
        check({name, "_data"},      {bus.result, bus.result_hi}, 0);
        check({name, "_flags"},     {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.illegal}, 0);
    endtask

    initial begin
        int waited;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sel       = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #2 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_in_ready",  bus.in_ready,  1);
        check("post_reset_out_valid", bus.out_valid, 0);

        // ADD / SUB flags, latency 1
        send(8'hFF, 8'h01, OP_ADD);
        check("add_latency", bus.out_valid, 1);
        send(8'h7F, 8'h01, OP_ADD);
        send(8'h80, 8'h01, OP_SUB);
        send(8'h01, 8'h02, OP_SUB);

        // MUL: 8-cycle busy window, product halves, carry
        mul_latency(8'h0F, 8'h11);
        mul_latency(8'hFF, 8'hFF);

        // Backpressure on XOR result, then drain and accept together
        send(8'h5A, 8'hFF, OP_XOR);
        bus.out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("hold_result",    bus.result,    8'hA5);
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_in_ready",  bus.in_ready,  0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        send(8'h12, 8'h34, OP_ADD);
        check("drain_accept_valid", bus.out_valid, 1);

        // Illegal opcode, shift modulo width, NOT
        send(8'h00, 8'h00, 4'hF);
        send(8'h01, 8'h09, OP_SHL);
        send(8'h00, 8'h0F, OP_NOT);

        // Reset in the fourth cycle of a MUL
        send(8'h0F, 8'h11, OP_MUL);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid_mul_reset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_rel_in_ready",  bus.in_ready,  1);
        check("rst_rel_out_valid", bus.out_valid, 0);
        repeat (12) @(posedge clk);
        #1 check("no_stale_out_valid", bus.out_valid, 0);

        // Randomized traffic with random backpressure
        bp_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send(W'($urandom), W'($urandom), SEL_W'($urandom_range(0, 15)));
        end
        bp_en = 1'b0;
        @(posedge clk);
        #2 bus.out_ready = 1'b1;
        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(posedge clk);
            waited++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1 check("final_out_valid", bus.out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
